// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder
//
// Ping-pong reorder buffer for the radar FFT datapath. Frames of N complex
// samples (N a power of two, 2^LOG2_MIN..2^LOG2_MAX) arrive in natural order
// and leave in bit-reversed index order, with N and the OR of all per-beat
// error codes carried alongside. Frames that are malformed are discarded and
// reported with a one-cycle frame_drop pulse.
//
// Handshake (both sides): a beat transfers on a rising clk edge where
// valid && ready, ready latency 0. While source_valid && !source_ready every
// source_* output and fftpts_out holds its value.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   sink_valid/ready             input beat handshake
//   sink_sop/eop, sink_error     input framing and per-beat error code
//   sink_real/imag, fftpts_in    input sample, frame length (taken at sop)
//   source_valid/ready           output beat handshake
//   source_sop/eop, source_error output framing and frame error code
//   source_real/imag, fftpts_out output sample, frame length
//   frame_drop                   pulse the cycle after a frame is rejected
//   dbg_state_o                  {reader state, writer state}

module fft_bitrev_reorder #(
    parameter int DW       = 32,
    parameter int LOG2_MAX = 7,
    parameter int LOG2_MIN = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sink_valid,
    output logic                sink_ready,
    input  logic [1:0]          sink_error,
    input  logic                sink_sop,
    input  logic                sink_eop,
    input  logic [DW-1:0]       sink_real,
    input  logic [DW-1:0]       sink_imag,
    input  logic [LOG2_MAX:0]   fftpts_in,
    output logic                source_valid,
    input  logic                source_ready,
    output logic [1:0]          source_error,
    output logic                source_sop,
    output logic                source_eop,
    output logic [DW-1:0]       source_real,
    output logic [DW-1:0]       source_imag,
    output logic [LOG2_MAX:0]   fftpts_out,
    output logic                frame_drop,
    output logic [2:0]          dbg_state_o
);

    localparam int DEPTH = 1 << LOG2_MAX;
    localparam int PW    = LOG2_MAX + 1;
    localparam int AW    = LOG2_MAX;
    localparam int LW    = $clog2(LOG2_MAX + 1);

    localparam logic [PW-1:0] PTS_ONE  = PW'(1);
    localparam logic [PW-1:0] PTS_MIN  = PW'(1) << LOG2_MIN;
    localparam logic [PW-1:0] PTS_MAX  = PW'(1) << LOG2_MAX;
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [LW-1:0] LG_MAX   = LW'(LOG2_MAX);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_FILL = 2'd1;
    localparam logic [1:0] W_SKIP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RUN  = 1'b1;

    // log2 of a power of two: position of its single set bit
    function automatic logic [LW-1:0] pts_log2(input logic [PW-1:0] n);
        logic [LW-1:0] lg;
        lg = '0;
        for (int i = 0; i < PW; i++) begin
            if (n[i]) lg = LW'(i);
        end
        return lg;
    endfunction

    // Reverse the low lg bits of k. Reversing all AW bits parks the low lg
    // bits at the top, so shifting right by AW-lg lands them in place.
    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] k,
                                             input logic [LW-1:0] lg);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < AW; i++) begin
            r[i] = k[AW-1-i];
        end
        return r >> (LG_MAX - lg);
    endfunction

    // ---------------------------------------------------------------- storage
    logic [2*DW-1:0] mem_q [2][DEPTH];

    logic [1:0]    full_q, full_d;
    logic          wb_q, wb_d;
    logic          rb_q, rb_d;
    logic [PW-1:0] bank_n_q   [2];
    logic [LW-1:0] bank_lg_q  [2];
    logic [1:0]    bank_err_q [2];

    // ----------------------------------------------------------------- writer
    logic [1:0]    w_state_q, w_state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] n_q, n_d;
    logic [LW-1:0] lg_q, lg_d;
    logic [1:0]    err_q, err_d;
    logic          drop_q, drop_d;
    logic          we;
    logic [AW-1:0] waddr;
    logic          commit;
    logic          sink_fire;
    logic          pts_legal;
    logic          cnt_last;

    assign sink_ready = ~full_q[wb_q];
    assign sink_fire  = sink_valid && sink_ready;
    assign pts_legal  = (fftpts_in >= PTS_MIN) && (fftpts_in <= PTS_MAX) &&
                        ((fftpts_in & (fftpts_in - PTS_ONE)) == '0);
    assign cnt_last   = ({1'b0, cnt_q} == (n_q - PTS_ONE));

    always_comb begin
        w_state_d = w_state_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        lg_d      = lg_q;
        err_d     = err_q;
        wb_d      = wb_q;
        drop_d    = 1'b0;
        we        = 1'b0;
        waddr     = cnt_q;
        commit    = 1'b0;
        if (sink_fire) begin
            if (sink_sop) begin
                // A sop always (re)starts a frame; an open frame is abandoned.
                if (w_state_q == W_FILL) drop_d = 1'b1;
                if (pts_legal) begin
                    we        = 1'b1;
                    waddr     = '0;
                    n_d       = fftpts_in;
                    lg_d      = pts_log2(fftpts_in);
                    err_d     = sink_error;
                    cnt_d     = ADDR_ONE;
                    w_state_d = W_FILL;
                end else begin
                    drop_d    = 1'b1;
                    w_state_d = W_SKIP;
                end
            end else begin
                case (w_state_q)
                    W_FILL: begin
                        if (cnt_last) begin
                            if (sink_eop) begin
                                we        = 1'b1;
                                commit    = 1'b1;
                                wb_d      = ~wb_q;
                                w_state_d = W_IDLE;
                            end else begin
                                drop_d    = 1'b1;
                                w_state_d = W_SKIP;
                            end
                        end else if (sink_eop) begin
                            drop_d    = 1'b1;
                            w_state_d = W_IDLE;
                        end else begin
                            we    = 1'b1;
                            cnt_d = cnt_q + ADDR_ONE;
                            err_d = err_q | sink_error;
                        end
                    end
                    W_SKIP: begin
                        if (sink_eop) w_state_d = W_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[wb_q][waddr] <= {sink_real, sink_imag};
    end

    // ----------------------------------------------------------------- reader
    // lb/lk track the beat to be loaded into the output register next; rb is
    // the bank whose frame is being presented and is released on its eop
    // transfer. lb runs ahead of rb by one frame across a frame boundary.
    logic [0:0]    r_state_q, r_state_d;
    logic          lb_q, lb_d;
    logic [AW-1:0] lk_q, lk_d;
    logic          load;
    logic          adv;
    logic          lk_last;
    logic [AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_data;

    logic          src_valid_q, src_valid_d;
    logic          src_sop_q, src_sop_d;
    logic          src_eop_q, src_eop_d;
    logic [1:0]    src_err_q, src_err_d;
    logic [DW-1:0] src_re_q, src_re_d;
    logic [DW-1:0] src_im_q, src_im_d;
    logic [PW-1:0] src_pts_q, src_pts_d;
    logic          src_eop_fire;

    assign adv          = !src_valid_q || source_ready;
    assign lk_last      = ({1'b0, lk_q} == (bank_n_q[lb_q] - PTS_ONE));
    assign rd_addr      = bitrev(lk_q, bank_lg_q[lb_q]);
    assign rd_data      = mem_q[lb_q][rd_addr];
    assign src_eop_fire = src_valid_q && source_ready && src_eop_q;

    always_comb begin
        r_state_d = r_state_q;
        lb_d      = lb_q;
        lk_d      = lk_q;
        load      = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                // One setup cycle before the first beat of an idle start.
                if (full_q[lb_q]) begin
                    r_state_d = R_RUN;
                    lk_d      = '0;
                end
            end
            R_RUN: begin
                if (adv) begin
                    load = 1'b1;
                    if (lk_last) begin
                        lb_d = ~lb_q;
                        lk_d = '0;
                        // Chain straight into the other bank when it is ready.
                        if (!full_q[~lb_q]) r_state_d = R_IDLE;
                    end else begin
                        lk_d = lk_q + ADDR_ONE;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        src_valid_d = src_valid_q;
        src_sop_d   = src_sop_q;
        src_eop_d   = src_eop_q;
        src_err_d   = src_err_q;
        src_re_d    = src_re_q;
        src_im_d    = src_im_q;
        src_pts_d   = src_pts_q;
        if (load) begin
            src_valid_d = 1'b1;
            src_sop_d   = (lk_q == '0);
            src_eop_d   = lk_last;
            src_err_d   = bank_err_q[lb_q];
            src_re_d    = rd_data[2*DW-1:DW];
            src_im_d    = rd_data[DW-1:0];
            src_pts_d   = bank_n_q[lb_q];
        end else if (source_ready) begin
            src_valid_d = 1'b0;
        end
    end

    // Writer commits and reader releases always target different banks.
    always_comb begin
        full_d = full_q;
        rb_d   = rb_q;
        if (commit) full_d[wb_q] = 1'b1;
        if (src_eop_fire) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
        end
    end

    // ------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_state_q   <= W_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            lg_q        <= '0;
            err_q       <= '0;
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            full_q      <= '0;
            drop_q      <= 1'b0;
            r_state_q   <= R_IDLE;
            lb_q        <= 1'b0;
            lk_q        <= '0;
            src_valid_q <= 1'b0;
            src_sop_q   <= 1'b0;
            src_eop_q   <= 1'b0;
            src_err_q   <= '0;
            src_re_q    <= '0;
            src_im_q    <= '0;
            src_pts_q   <= '0;
        end else begin
            w_state_q   <= w_state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            lg_q        <= lg_d;
            err_q       <= err_d;
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            full_q      <= full_d;
            drop_q      <= drop_d;
            r_state_q   <= r_state_d;
            lb_q        <= lb_d;
            lk_q        <= lk_d;
            src_valid_q <= src_valid_d;
            src_sop_q   <= src_sop_d;
            src_eop_q   <= src_eop_d;
            src_err_q   <= src_err_d;
            src_re_q    <= src_re_d;
            src_im_q    <= src_im_d;
            src_pts_q   <= src_pts_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                bank_n_q[b]   <= '0;
                bank_lg_q[b]  <= '0;
                bank_err_q[b] <= '0;
            end
        end else if (commit) begin
            bank_n_q[wb_q]   <= n_q;
            bank_lg_q[wb_q]  <= lg_q;
            bank_err_q[wb_q] <= err_q | sink_error;
        end
    end

    assign source_valid = src_valid_q;
    assign source_sop   = src_sop_q;
    assign source_eop   = src_eop_q;
    assign source_error = src_err_q;
    assign source_real  = src_re_q;
    assign source_imag  = src_im_q;
    assign fftpts_out   = src_pts_q;
    assign frame_drop   = drop_q;
    assign dbg_state_o  = {r_state_q, w_state_q};

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: frames are driven through the sink, a
// reference model computes the bit-reversed output stream with plain
// arithmetic, and the captured source stream is compared beat by beat.

module tb_fft_bitrev_reorder;

    localparam int DW   = 32;
    localparam int LMAX = 7;
    localparam int LMIN = 3;
    localparam int PW   = LMAX + 1;
    localparam int W    = 4 + PW + 2 * DW;

    // ------------------------------------------------ clock / reset / DUT
    logic          clk = 1'b0;
    logic          reset_n;
    logic          sink_valid, sink_ready, sink_sop, sink_eop;
    logic [1:0]    sink_error;
    logic [DW-1:0] sink_real, sink_imag;
    logic [PW-1:0] fftpts_in;
    logic          source_valid, source_ready, source_sop, source_eop;
    logic [1:0]    source_error;
    logic [DW-1:0] source_real, source_imag;
    logic [PW-1:0] fftpts_out;
    logic          frame_drop;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fft_bitrev_reorder #(.DW(DW), .LOG2_MAX(LMAX), .LOG2_MIN(LMIN)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sink_valid   (sink_valid),
        .sink_ready   (sink_ready),
        .sink_error   (sink_error),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_real    (sink_real),
        .sink_imag    (sink_imag),
        .fftpts_in    (fftpts_in),
        .source_valid (source_valid),
        .source_ready (source_ready),
        .source_error (source_error),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_real  (source_real),
        .source_imag  (source_imag),
        .fftpts_out   (fftpts_out),
        .frame_drop   (frame_drop),
        .dbg_state_o  (dbg_state)
    );

    // ------------------------------------------------ scoreboard state
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    int           obs_cyc_q[$];
    int           drop_cycles = 0;
    int           exp_drops = 0;
    int           stall_cnt = 0;
    bit           lat_arm = 0;
    int           lat_cyc = 0;
    int           vectors = 0;
    int           miscompares = 0;

    function automatic logic [W-1:0] pack(input logic [1:0] e, input logic s,
                                          input logic eo, input logic [PW-1:0] p,
                                          input logic [DW-1:0] re,
                                          input logic [DW-1:0] im);
        return {e, s, eo, p, re, im};
    endfunction

    // Output monitor: a beat seen valid && ready mid-cycle transfers at the
    // next rising edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (source_valid && source_ready) begin
                obs_q.push_back(pack(source_error, source_sop, source_eop,
                                     fftpts_out, source_real, source_imag));
                obs_cyc_q.push_back(cyc);
            end
            if (frame_drop) drop_cycles++;
            if (lat_arm && source_valid) begin
                lat_cyc = cyc;
                lat_arm = 0;
            end
        end
    end

    // ------------------------------------------------ reference model
    function automatic bit pts_legal(input int p);
        for (int l = LMIN; l <= LMAX; l++) begin
            if (p == (1 << l)) return 1;
        end
        return 0;
    endfunction

    function automatic int log2i(input int p);
        int l = 0;
        while ((1 << l) < p) l++;
        return l;
    endfunction

    function automatic int rev_bits(input int k, input int l);
        int j = 0;
        int t = k;
        for (int i = 0; i < l; i++) begin
            j = j * 2 + t % 2;
            t = t / 2;
        end
        return j;
    endfunction

    // ------------------------------------------------ drivers
    task automatic drive_beat(input logic [DW-1:0] re, input logic [DW-1:0] im,
                              input logic s, input logic eo,
                              input logic [1:0] e, input logic [PW-1:0] p);
        int w = 0;
        sink_real  = re;
        sink_imag  = im;
        sink_sop   = s;
        sink_eop   = eo;
        sink_error = e;
        fftpts_in  = p;
        sink_valid = 1'b1;
        @(negedge clk);
        while (!sink_ready && w < 1000) begin
            w++;
            stall_cnt++;
            @(negedge clk);
        end
        if (!sink_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL sink_accept_timeout: sink_ready=%0b after %0d cycles, required 1", sink_ready, w);
        end
        @(posedge clk);
        #1;
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        sink_error = 2'b00;
    endtask

    // Sends nbeats beats tagged with length pts (sop on beat 0, eop on the
    // last beat when do_eop) and records what the block must produce.
    task automatic send_frame(input int pts, input int nbeats, input int err_beat,
                              input logic [1:0] err_val, input bit do_eop,
                              input bit ramp);
        logic [DW-1:0] re[$];
        logic [DW-1:0] im[$];
        logic [1:0]    acc;
        acc = 2'b00;
        for (int i = 0; i < nbeats; i++) begin
            logic [1:0] e;
            re.push_back(ramp ? DW'(i) : DW'($urandom));
            im.push_back(DW'($urandom));
            e = (i == err_beat) ? err_val : 2'b00;
            acc = acc | e;
            drive_beat(re[i], im[i], i == 0, do_eop && (i == nbeats - 1), e, PW'(pts));
        end
        if (do_eop) begin
            if (pts_legal(pts) && nbeats == pts) begin
                for (int k = 0; k < pts; k++) begin
                    int j;
                    j = rev_bits(k, log2i(pts));
                    exp_q.push_back(pack(acc, k == 0, k == pts - 1, PW'(pts), re[j], im[j]));
                end
            end else begin
                exp_drops++;
            end
        end
    endtask

    task automatic wait_drain(input int want, output bit ok);
        int w = 0;
        while (obs_q.size() < want && w < 3000) begin
            @(negedge clk);
            w++;
        end
        repeat (20) @(negedge clk);
        ok = (obs_q.size() == want);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        obs_cyc_q.delete();
        drop_cycles = 0;
        exp_drops = 0;
        stall_cnt = 0;
    endtask

    // ------------------------------------------------ tests
    task automatic test_reset();
        reset_n      = 1'b0;
        sink_valid   = 1'b0;
        sink_sop     = 1'b0;
        sink_eop     = 1'b0;
        sink_error   = 2'b00;
        sink_real    = '0;
        sink_imag    = '0;
        fftpts_in    = '0;
        source_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (sink_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_sink_ready: got %0b, required 1", sink_ready);
        end
        vectors++;
        if ({source_valid, source_sop, source_eop, frame_drop, source_error, fftpts_out,
             source_real, source_imag} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%0b sop=%0b eop=%0b drop=%0b err=%0d pts=%0d re=%h im=%h, required all 0",
                     source_valid, source_sop, source_eop, frame_drop, source_error,
                     fftpts_out, source_real, source_imag);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic_n8();
        bit ok;
        int eop_cyc;
        clear_sb();
        send_frame(8, 8, -1, 2'b00, 1, 1);
        eop_cyc = cyc;
        lat_arm = 1;
        wait_drain(exp_q.size(), ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL basic_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL basic_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (lat_cyc - eop_cyc !== 2) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d cycles, required 2", lat_cyc - eop_cyc);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int gaps = 0;
        clear_sb();
        send_frame(128, 128, -1, 2'b00, 1, 0);
        send_frame(128, 128, $urandom_range(0, 127), 2'($urandom_range(1, 3)), 1, 0);
        vectors++;
        if (stall_cnt !== 0) begin
            miscompares++;
            $display("FAIL b2b_sink_stall: got %0d stall cycles, required 0", stall_cnt);
        end
        wait_drain(exp_q.size(), ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL b2b_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        for (int i = 1; i < obs_cyc_q.size(); i++) begin
            if (obs_cyc_q[i] - obs_cyc_q[i-1] != 1) gaps++;
        end
        vectors++;
        if (gaps !== 0) begin
            miscompares++;
            $display("FAIL b2b_gaps: got %0d output gaps, required 0", gaps);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit bp_done = 0;
        clear_sb();
        source_ready = 1'b0;
        fork
            begin
                send_frame(16, 16, -1, 2'b00, 1, 0);
                send_frame(16, 16, 5, 2'b01, 1, 0);
                @(negedge clk);
                vectors++;
                if (sink_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_ready_low: got %0b, required 0", sink_ready);
                end
                send_frame(16, 16, -1, 2'b00, 1, 0);
                vectors++;
                if (obs_q.size() < 16) begin
                    miscompares++;
                    $display("FAIL bp_third_early: got %0d beats drained, required >= 16", obs_q.size());
                end
            end
            begin
                repeat (60) @(posedge clk);
                #1;
                for (int c = 0; c < 800 && obs_q.size() < 48; c++) begin
                    source_ready = ~source_ready;
                    @(posedge clk);
                    #1;
                end
                source_ready = 1'b1;
                bp_done = 1;
            end
            begin
                logic [W:0] prev, cur;
                bit hold = 0;
                prev = '0;
                for (int c = 0; c < 1500 && !bp_done; c++) begin
                    @(negedge clk);
                    cur = {source_valid, pack(source_error, source_sop, source_eop,
                                              fftpts_out, source_real, source_imag)};
                    if (hold) begin
                        vectors++;
                        if (cur !== prev) begin
                            miscompares++;
                            $display("FAIL bp_hold: got %h, required %h", cur, prev);
                        end
                    end
                    prev = cur;
                    hold = source_valid && !source_ready;
                end
            end
        join
        wait_drain(exp_q.size(), ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL bp_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL bp_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_drop_and_error();
        bit ok;
        clear_sb();
        source_ready = 1'b1;
        send_frame(8, 6, -1, 2'b00, 1, 0);
        @(negedge clk);
        vectors++;
        if (frame_drop !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_pulse: got %0b, required 1", frame_drop);
        end
        @(negedge clk);
        vectors++;
        if (frame_drop !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_width: got %0b, required 0", frame_drop);
        end
        @(posedge clk);
        #1;
        send_frame(8, 10, -1, 2'b00, 1, 0);
        send_frame(12, 12, -1, 2'b00, 1, 0);
        send_frame(4, 4, -1, 2'b00, 1, 0);
        send_frame(0, 8, -1, 2'b00, 1, 0);
        send_frame(8, 8, -1, 2'b00, 1, 1);
        send_frame(16, 16, 3, 2'b10, 1, 0);
        wait_drain(exp_q.size(), ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL drop_count_beats: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL drop_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (drop_cycles !== exp_drops) begin
            miscompares++;
            $display("FAIL drop_total: got %0d drop cycles, required %0d", drop_cycles, exp_drops);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_sb();
        source_ready = 1'b1;
        send_frame(32, 10, -1, 2'b00, 0, 0);
        reset_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({source_valid, frame_drop, fftpts_out, ~sink_ready} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_frame: valid=%0b drop=%0b pts=%0d ready=%0b, required 0/0/0/1",
                     source_valid, frame_drop, fftpts_out, sink_ready);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        source_ready = 1'b0;
        send_frame(16, 16, -1, 2'b00, 1, 0);
        send_frame(16, 16, -1, 2'b00, 1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (source_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre_valid: got %0b, required 1", source_valid);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({source_valid, source_sop, source_eop, frame_drop, source_error, fftpts_out,
             source_real, source_imag} !== '0 || sink_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_output: valid=%0b sop=%0b eop=%0b pts=%0d re=%h ready=%0b, required reset values",
                     source_valid, source_sop, source_eop, fftpts_out, source_real, sink_ready);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_sb();
        source_ready = 1'b1;
        send_frame(32, 32, $urandom_range(0, 31), 2'($urandom_range(0, 3)), 1, 0);
        wait_drain(exp_q.size(), ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rst_after_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL rst_after_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    // ------------------------------------------------ sequence and report
    initial begin
        test_reset();
        test_basic_n8();
        test_back_to_back();
        test_backpressure();
        test_drop_and_error();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Parametrised Avalon-ST reorder buffer for the radar FFT datapath. It accepts variable-length complex frames in natural order and emits each frame in bit-reversed index order, with per-frame length carried alongside. It sits between the sample framer and the FFT core, or after a core that outputs bit-reversed data. Ping-pong banking sustains one sample per cycle across back-to-back frames, and malformed frames are dropped with a status pulse.

## Interface
Parameters:
- DW, 32: width of each of real/imag.
- LOG2_MAX, 7: log2 of maximum points (128); bank depth 2^LOG2_MAX.
- LOG2_MIN, 3: log2 of minimum legal points (8).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- sink_valid  in  1  input beat valid.
- sink_ready  out  1  block can accept a beat.
- sink_error  in  2  per-beat error code.
- sink_sop  in  1  first beat of frame.
- sink_eop  in  1  last beat of frame.
- sink_real  in  DW  real sample.
- sink_imag  in  DW  imaginary sample.
- fftpts_in  in  LOG2_MAX+1  frame length N, power of two; sampled on the sop beat.
- source_valid  out  1  output beat valid.
- source_ready  in  1  downstream accepts the beat.
- source_error  out  2  OR of all sink_error bits accepted in the frame.
- source_sop  out  1  first output beat.
- source_eop  out  1  last output beat.
- source_real  out  DW  reordered real sample.
- source_imag  out  DW  reordered imaginary sample.
- fftpts_out  out  LOG2_MAX+1  N of the frame being output.
- frame_drop  out  1  one-cycle pulse when an input frame is discarded.

## Operation
- Beat transfer: a beat transfers when valid && ready, with ready latency 0, on both sides.
- Storage: two banks, each 2^LOG2_MAX x 2*DW. Per-bank flag full[b]. Write pointer wb and read pointer rb each toggle independently.
- sink_ready = ~full[wb].
- Writer FSM W_IDLE:
  - A beat without sop is ignored.
  - A sop beat with legal N (a power of two in [2^LOG2_MIN, 2^LOG2_MAX]) is written to addr 0, latches N, and sets err = sink_error. Next state W_FILL, cnt = 1.
  - A sop beat with illegal N pulses frame_drop. Next state W_SKIP.
- Writer FSM W_FILL: each beat writes addr cnt and ORs its sink_error into err.
  - eop with cnt == N-1: set full[wb], store N and err with the bank, toggle wb, go to W_IDLE.
  - eop with cnt < N-1: frame_drop, go to W_IDLE.
  - cnt == N-1 without eop: frame_drop, go to W_SKIP.
  - sop mid-frame: frame_drop, then restart the frame with this beat exactly as in W_IDLE.
- Writer FSM W_SKIP: discard beats until an eop beat, then go to W_IDLE. A sop beat restarts a frame as in W_IDLE.
- Reader:
  - When full[rb] is set, output k = 0..N-1 reads addr bitrev_L(k), where L = log2 N. Only the low L bits are reversed.
  - sop on k = 0, eop on k = N-1. fftpts_out and source_error come from the bank's stored values and are constant for the whole frame.
  - The eop transfer clears full[rb] and toggles rb.
- Backpressure: while source_valid && !source_ready, all source_* outputs and fftpts_out hold stable.
- Simultaneous events: a writer commit and a reader release on different banks in the same cycle both take effect. If the writer is blocked on bank b and the reader releases b in cycle t, sink_ready rises in cycle t+1.

## Timing
- Reset values:
  - sink_ready = 1.
  - source_valid, source_sop, source_eop, frame_drop = 0.
  - source_error = 0, source_real/imag = 0, fftpts_out = 0.
  - full = 00, wb = rb = 0, both FSMs idle.
- Reset mid-frame discards all buffered and partial frames. No output beats appear afterwards for pre-reset data.
- Latency: input eop accepted at edge t gives the first source_valid at edge t+2 when the reader is idle.
- Throughput: one beat/cycle sustained when source_ready = 1. Consecutive output frames have no idle cycle between them if the next bank is already full.
- frame_drop is high for exactly the cycle after the offending beat.
- sink_ready falls the cycle after the second bank commits while the first bank is still unread.

## Test plan
- N = 8, natural samples 0..7 -> output real 0,4,2,6,1,5,3,7; sop on 0, eop on 7; fftpts_out = 8; first valid 2 cycles after input eop.
- Two back-to-back N = 128 frames with source_ready = 1 -> 256 contiguous output beats, bit-reversed order, no gaps, no sink_ready deassertion.
- Three N = 16 frames with source_ready = 0 -> sink_ready goes low after the 2nd frame commits. Then set source_ready = 1 on alternate cycles -> outputs held stable while stalled, all data correct, 3rd frame accepted after the first frame drains.
- N = 8 with eop on beat 5 -> frame_drop pulse, no output. Following legal frame output correctly.
- fftpts_in = 12 or 256 -> frame_drop, all beats skipped until eop. sink_error = 2'b10 on beat 3 of a legal frame -> source_error = 2'b10 on every beat of that output frame.
- reset_n low mid-frame and while outputting -> all outputs at reset values. After release, an N = 32 frame reorders correctly.
